// File: rtl/ks_serial_add_ctrl.sv
// Multi-word add/subtract sequencer that streams N-bit slices through one Kogge-Stone adder.
// Also holds KoggeStone_par, the combinational parallel-prefix slice adder it drives.

module KoggeStone_par #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int Levels = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        logic [N-1:0] p0;
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] g_nx;
        logic [N-1:0] p_nx;
        logic [N:0]   c;

        p0   = a ^ b;
        g    = a & b;
        p    = p0;
        g_nx = '0;
        p_nx = '0;
        c    = '0;

        // Prefix tree: after level l, (g[i], p[i]) span bits i down to i-2^(l+1)+1.
        for (int l = 0; l < Levels; l++) begin
            g_nx = g;
            p_nx = p;
            for (int i = 0; i < int'(N); i++) begin
                if (i >= (1 << l)) begin
                    g_nx[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p_nx[i] = p[i] & p[i - (1 << l)];
                end
            end
            g = g_nx;
            p = p_nx;
        end

        c[0] = cin;
        for (int i = 0; i < int'(N); i++) begin
            c[i+1] = g[i] | (p[i] & cin);
        end

        sum  = p0 ^ c[N-1:0];
        cout = c[N];
    end

endmodule

module ks_serial_add_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               busy
);

    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [N-1:0]    slice_a;
    logic [N-1:0]    slice_b;
    logic [N-1:0]    slice_sum;
    logic            slice_cout;
    logic            last_slice;

    assign slice_a    = a_q[idx_q*N +: N];
    assign slice_b    = b_q[idx_q*N +: N];
    assign last_slice = (idx_q == IdxW'(WORDS - 1));

    KoggeStone_par #(
        .N (N)
    ) u_slice_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1; cin is deliberately overridden.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*N +: N] = slice_sum;
                carry_d             = slice_cout;
                if (last_slice) begin
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_serial_add_ctrl.sv
// Directed bench for ks_serial_add_ctrl with N=4, WORDS=4 (16-bit operands).

module tb_ks_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks;
    int passed;

    ks_serial_add_ctrl #(
        .N     (4),
        .WORDS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for one cycle, then returns cycles until out_valid (capped at 20).
    task automatic start_op(input logic [15:0] op_a, input logic [15:0] op_b,
                            input logic op_cin, input logic op_sub, output int lat);
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        sub      = op_sub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (sum !== 16'h0000) $display("FAIL rst_sum: got %h want 0000", sum); else passed++;
        checks++; if ({cout, ovf} !== 2'b00) $display("FAIL rst_cout_ovf: got %b want 00", {cout, ovf}); else passed++;
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_basic_add();
        int lat;
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) $display("FAIL add_latency: got %0d want 4", lat); else passed++;
        checks++; if (sum !== 16'h5555) $display("FAIL add_sum: got %h want 5555", sum); else passed++;
        checks++; if ({cout, ovf} !== 2'b00) $display("FAIL add_cout_ovf: got %b want 00", {cout, ovf}); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL add_done_ready: got %b want 0", in_ready); else passed++;
        release_op();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL add_back_idle: got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
    endtask

    task automatic test_carry_ripple();
        int lat;
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (sum !== 16'h0000) $display("FAIL ripple1_sum: got %h want 0000", sum); else passed++;
        checks++; if ({cout, ovf} !== 2'b10) $display("FAIL ripple1_cout_ovf: got %b want 10", {cout, ovf}); else passed++;
        release_op();
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
        checks++; if (sum !== 16'h0000) $display("FAIL ripple2_sum: got %h want 0000", sum); else passed++;
        checks++; if (cout !== 1'b1) $display("FAIL ripple2_cout: got %b want 1", cout); else passed++;
        release_op();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (sum !== 16'h8000) $display("FAIL ovf_sum: got %h want 8000", sum); else passed++;
        checks++; if ({cout, ovf} !== 2'b01) $display("FAIL ovf_cout_ovf: got %b want 01", {cout, ovf}); else passed++;
        release_op();
    endtask

    task automatic test_subtract();
        int lat;
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        checks++; if (sum !== 16'hFFFE) $display("FAIL sub1_sum: got %h want fffe", sum); else passed++;
        checks++; if ({cout, ovf} !== 2'b00) $display("FAIL sub1_cout_ovf: got %b want 00", {cout, ovf}); else passed++;
        release_op();
        start_op(16'h8000, 16'h0001, 1'b1, 1'b1, lat);
        checks++; if (sum !== 16'h7FFF) $display("FAIL sub2_sum: got %h want 7fff", sum); else passed++;
        checks++; if ({cout, ovf} !== 2'b11) $display("FAIL sub2_cout_ovf: got %b want 11", {cout, ovf}); else passed++;
        release_op();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat);
        a         = 16'h1111;
        b         = 16'h2222;
        cin       = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (sum !== 16'h0003) $display("FAIL bp_hold_sum: got %h want 0003", sum); else passed++;
            checks++; if ({cout, ovf} !== 2'b00) $display("FAIL bp_hold_flags: got %b want 00", {cout, ovf}); else passed++;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL bp_hold_hs: got ready=%b valid=%b want 0/1", in_ready, out_valid); else passed++;
        end
        out_ready = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release_idle: got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL bp_accept_busy: got %b want 1", busy); else passed++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++; if (lat !== 4) $display("FAIL bp_latency: got %0d want 4", lat); else passed++;
        checks++; if (sum !== 16'h3333) $display("FAIL bp_new_sum: got %h want 3333", sum); else passed++;
        release_op();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midrst_hs: got valid=%b busy=%b ready=%b want 0/0/1", out_valid, busy, in_ready);
        else passed++;
        checks++; if (sum !== 16'h0000) $display("FAIL midrst_sum: got %h want 0000", sum); else passed++;
        step();
        step();
        rst_n = 1'b1;
        step();
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) $display("FAIL midrst_latency: got %0d want 4", lat); else passed++;
        checks++; if (sum !== 16'h0100) $display("FAIL midrst_sum_after: got %h want 0100", sum); else passed++;
        checks++; if (cout !== 1'b0) $display("FAIL midrst_cout_after: got %b want 0", cout); else passed++;
        release_op();
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        step();
        step();
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_overflow();
        test_subtract();
        test_backpressure();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ks_serial_add_ctrl.md
# ks_serial_add_ctrl

Multi-word add/subtract sequencer around one shared `KoggeStone_par` slice adder. It accepts W = N·WORDS-bit operands through a valid/ready handshake and feeds one N-bit slice per cycle, LSB slice first, into the internal adder. It registers the inter-slice carry and assembles the full-width sum. It returns sum, carry-out and signed overflow through a second valid/ready handshake, so wide additions reuse a small parallel-prefix adder.

## Interface
- N, 4, slice width; width of the internal `KoggeStone_par` instance.
- WORDS, 4, number of slices per operation (≥1); W = N·WORDS.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1: compute a − b (two's complement).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  W  result.
- cout  output  1  carry out of MSB; in subtract mode, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  operation in progress (state ≠ IDLE).

## Operation
- One clock and one reset: `clk`, plus `rst_n`, which is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- **IDLE:** on in_valid && in_ready:
  - latch a into a_r, and (sub ? ~b : b) into b_r;
  - carry_r ← sub ? 1 : cin;
  - idx ← 0; out_valid already low; go to RUN.
- **RUN:**
  - The adder sees a_r[idx·N +: N], b_r[idx·N +: N], Cin = carry_r.
  - At each edge: sum_r[idx·N +: N] ← slice Sum; carry_r ← slice Cout; idx ← idx+1.
  - When idx == WORDS−1, additionally go to DONE:
    - cout ← slice Cout;
    - ovf ← (a_msb == beff_msb) && (sum_msb ≠ a_msb), where beff_msb is the MSB of the inverted B when subtracting.
- **DONE:** sum, cout, ovf held stable. On out_ready, go to IDLE next edge. Without out_ready, stay indefinitely.
- No overlap: new operands are accepted only in IDLE. in_valid in RUN/DONE is ignored and must be held by the producer.
- idx counter width is clog2(WORDS), minimum 1. It never wraps past WORDS−1.
- sum upper slices keep prior-operation values until overwritten during RUN. Only values in DONE are defined.

## Timing
- **Reset values:**
  - state = IDLE, so in_ready = 1 and busy = 0;
  - out_valid = 0, sum = 0, cout = 0, ovf = 0;
  - internal idx, carry_r, a_r and b_r = 0.
- **Latency:** operands accepted at edge k. RUN occupies edges k+1 … k+WORDS. out_valid is high after edge k+WORDS, i.e. WORDS cycles after acceptance.
- **Throughput:** with out_ready tied high, one operation per WORDS+2 cycles (DONE 1 cycle, IDLE 1 cycle).
- **WORDS = 1:** RUN lasts exactly one cycle; latency 1.
- Critical path: one N-bit Kogge-Stone slice plus the carry_r mux. carry_r is the only inter-slice carry path (registered).
- **Reset mid-operation** (any state): outputs return to reset values immediately (asynchronous). The aborted result is never presented. The first post-release handshake starts a clean operation.
- **Simultaneous events:** in DONE, out_ready together with in_valid does not accept new operands that cycle. Acceptance happens in the following IDLE cycle.

## Test plan
N=4, WORDS=4, W=16.
- **Basic add:** a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the in handshake.
- **Full carry ripple across all slices:** a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- **Signed overflow add:** a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- **Subtract:**
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0;
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1;
  - cin=1 ignored in both.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE while asserting in_valid with new operands → sum, cout and ovf are unchanged, in_ready=0, and nothing is accepted. Raise out_ready → IDLE next cycle, and the new operands are accepted that cycle.
- **Reset during RUN:** with idx=2, drive rst_n low for 2 cycles → out_valid=0, sum=0, busy=0, in_ready=1 immediately. After release, a=0x00FF, b=0x0001 → sum=0x0100, cout=0.
